instruction_decode: RTL and testbench
=====================================

Name: instruction_decode

Overview:
- Decode stage of the 16-bit pipelined core, directly downstream of instruction fetch.
- Consumes NPC_IF/INST_IF, holds the 16-entry register file, and resolves branches/jumps, driving TARGET/TARGET_EN back to fetch.
- Squashes the wrong-path instruction after a redirect and registers decoded operands/controls into the ID/EX pipeline register.

Parameters:
- DATA_W, 16, datapath and instruction width.
- REG_AW, 4, register index width (2**REG_AW registers).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- NPC_IF  in  16  address of the fetched instruction + 1.
- INST_IF  in  16  fetched instruction.
- WB_EN  in  1  writeback enable.
- WB_ADDR  in  4  writeback register index.
- WB_DATA  in  16  writeback data.
- TARGET  out  16  redirect address to fetch (combinational).
- TARGET_EN  out  1  redirect valid (combinational).
- NPC_ID  out  16  registered NPC_IF.
- A_ID  out  16  operand A.
- B_ID  out  16  operand B / store data.
- IMM_ID  out  16  sign-extended imm8.
- RD_ID  out  4  destination index.
- ALU_OP_ID  out  3  ALU function.
- REG_WE_ID  out  1  register write.
- MEM_RE_ID  out  1  load.
- MEM_WE_ID  out  1  store.
- VALID_ID  out  1  ID/EX holds a real instruction.
- HALTED  out  1  core halted.

Behaviour:
- Encoding: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm8=[7:0].
- op 0x0-0x7, R-type: A=R[rs], B=R[rt], ALU_OP=op[2:0], REG_WE=1, RD=rd.
- op 0x8, ADDI: A=R[rd], IMM=sext(imm8), ALU_OP=0, REG_WE=1, RD=rd.
- op 0x9, LOAD: A=R[rs], MEM_RE=1, REG_WE=1, RD=rd.
- op 0xA, STORE: A=R[rs], B=R[rd], MEM_WE=1, REG_WE=0.
- op 0xB, BZ: if R[rd]==0, TARGET=NPC_IF+sext(imm8), modulo 2^16; no writes.
- op 0xC, JR: TARGET=R[rs] unconditionally; no writes.
- op 0xD, 0xE: NOP, valid bubble with all enables 0.
- op 0xF: HALT.

Register file:
- 16x16; R0 always reads 0, and writes to R0 are ignored.
- Write occurs on the rising edge when WB_EN=1.
- Read is combinational with write-through bypass: if WB_EN and WB_ADDR==source index (and index!=0), the read returns WB_DATA in the same cycle.

State machine (states RUN, SQUASH, HALT):
- RUN:
  - Decode INST_IF; register the results into ID/EX with VALID_ID=1.
  - Taken BZ or JR: TARGET_EN=1 during this cycle; the instruction itself still enters ID/EX (VALID_ID=1, no enables); next state SQUASH.
  - HALT: capture halt_pc=NPC_IF-1; next state HALT.
- SQUASH:
  - INST_IF is wrong-path: ID/EX gets a bubble (VALID_ID=0, all enables 0).
  - TARGET_EN=0; next state RUN.
- HALT:
  - ID/EX bubbles every cycle; HALTED=1.
  - TARGET=halt_pc and TARGET_EN=1 every cycle, so fetch spins.
  - Sticky until rst.
- In SQUASH and HALT, a branch or HALT encoding in INST_IF is ignored.
- Outside RUN taken-branch cycles and HALT, TARGET_EN=0 and TARGET=0.

Reset (asynchronous):
- State goes to SQUASH, so the first post-reset fetch word is discarded.
- All ID/EX outputs, HALTED and halt_pc go to 0; all registers go to 0.
- Reset mid-branch or mid-halt returns to SQUASH immediately; TARGET_EN drops combinationally.

Latency and write behaviour:
- One cycle from INST_IF to ID/EX outputs.
- Branch decision is zero-cycle combinational, with a one-instruction penalty (the SQUASH cycle).
- WB writes proceed in every state, including HALT and SQUASH.

Test Plan:
- Reset then R-type: after the reset SQUASH cycle, WB writes R2=0x0005 and R3=0x0003, INST_IF=0x1123 -> next edge A_ID=0x0005, B_ID=0x0003, ALU_OP_ID=1, RD_ID=1, REG_WE_ID=1, VALID_ID=1.
- Bypass: WB_EN=1, WB_ADDR=4, WB_DATA=0xBEEF in the same cycle as INST_IF=0x0045 -> A_ID=0xBEEF; with WB_ADDR=0 and INST_IF=0x0005 -> A_ID=0x0000.
- Taken BZ: R1=0, NPC_IF=0x0010, INST_IF=0xB1FE -> TARGET_EN=1 and TARGET=0x000E that cycle; the following cycle's INST_IF produces VALID_ID=0; operation resumes normally the cycle after.
- Not-taken BZ / JR / wrap-around:
  - R1=7 -> TARGET_EN=0, no squash.
  - JR with R5=0x1234 -> TARGET=0x1234.
  - BZ with NPC_IF=0xFFFF, imm=0x02 -> TARGET=0x0001.
- HALT: NPC_IF=0x0021, INST_IF=0xF000 -> next cycle HALTED=1, TARGET=0x0020, TARGET_EN=1, VALID_ID=0 indefinitely; rst asserted -> HALTED=0 asynchronously.
- ADDI/STORE: INST_IF=0x82FF -> IMM_ID=0xFFFF, RD_ID=2; INST_IF=0xA360 -> MEM_WE_ID=1, REG_WE_ID=0, B_ID=R3.

Source files
------------

// File: rtl/instruction_decode.sv
// instruction_decode: decode stage of the 16-bit pipelined core.
// Reads the fetched instruction, holds the register file, resolves BZ/JR
// redirects toward fetch and fills the ID/EX pipeline register.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   NPC_IF, INST_IF           fetched instruction and its address + 1
//   WB_EN, WB_ADDR, WB_DATA   register file write port
//   TARGET, TARGET_EN         combinational redirect to fetch
//   NPC_ID .. MEM_WE_ID       registered decode results (ID/EX)
//   VALID_ID                  ID/EX holds a real instruction
//   HALTED                    core halted (sticky until reset)
//
// state  | meaning
// RUN    | decode INST_IF normally
// SQUASH | INST_IF is wrong-path (post-redirect or post-reset), bubble it
// HALT   | HALT seen; bubble forever, hold fetch at halt_pc
module instruction_decode #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] NPC_IF,
  input  logic [DATA_W-1:0] INST_IF,
  input  logic              WB_EN,
  input  logic [REG_AW-1:0] WB_ADDR,
  input  logic [DATA_W-1:0] WB_DATA,
  output logic [DATA_W-1:0] TARGET,
  output logic              TARGET_EN,
  output logic [DATA_W-1:0] NPC_ID,
  output logic [DATA_W-1:0] A_ID,
  output logic [DATA_W-1:0] B_ID,
  output logic [DATA_W-1:0] IMM_ID,
  output logic [REG_AW-1:0] RD_ID,
  output logic [2:0]        ALU_OP_ID,
  output logic              REG_WE_ID,
  output logic              MEM_RE_ID,
  output logic              MEM_WE_ID,
  output logic              VALID_ID,
  output logic              HALTED
);

  localparam int NREG = 2 ** REG_AW;

  typedef enum logic [1:0] {ST_RUN, ST_SQUASH, ST_HALT} state_t;

  state_t            state;
  logic [DATA_W-1:0] halt_pc;
  logic [DATA_W-1:0] regs [NREG];

  logic [3:0]        op;
  logic [REG_AW-1:0] f_rd, f_rs, f_rt;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] rd_val, rs_val, rt_val;
  logic              br_taken;

  logic [DATA_W-1:0] d_a, d_b, d_imm;
  logic [REG_AW-1:0] d_rd;
  logic [2:0]        d_alu;
  logic              d_we, d_re, d_mwe;

  assign op       = INST_IF[15:12];
  assign f_rd     = INST_IF[11:8];
  assign f_rs     = INST_IF[7:4];
  assign f_rt     = INST_IF[3:0];
  assign imm_sext = {{(DATA_W-8){INST_IF[7]}}, INST_IF[7:0]};

  // Register file: R0 is never written and always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (WB_EN && (WB_ADDR != '0)) begin
      regs[WB_ADDR] <= WB_DATA;
    end
  end

  // Read ports with write-through so a same-cycle writeback is visible.
  always_comb begin
    rd_val = '0;
    rs_val = '0;
    rt_val = '0;
    if (f_rd != '0) rd_val = (WB_EN && WB_ADDR == f_rd) ? WB_DATA : regs[f_rd];
    if (f_rs != '0) rs_val = (WB_EN && WB_ADDR == f_rs) ? WB_DATA : regs[f_rs];
    if (f_rt != '0) rt_val = (WB_EN && WB_ADDR == f_rt) ? WB_DATA : regs[f_rt];
  end

  assign br_taken = (state == ST_RUN) &&
                    (((op == 4'hB) && (rd_val == '0)) || (op == 4'hC));

  always_comb begin
    TARGET    = '0;
    TARGET_EN = 1'b0;
    if (state == ST_HALT) begin
      TARGET    = halt_pc;
      TARGET_EN = 1'b1;
    end else if (br_taken) begin
      TARGET    = (op == 4'hB) ? (NPC_IF + imm_sext) : rs_val;
      TARGET_EN = 1'b1;
    end
  end

  always_comb begin
    d_a   = '0;
    d_b   = '0;
    d_imm = '0;
    d_rd  = '0;
    d_alu = '0;
    d_we  = 1'b0;
    d_re  = 1'b0;
    d_mwe = 1'b0;
    if (!op[3]) begin
      d_a   = rs_val;
      d_b   = rt_val;
      d_alu = op[2:0];
      d_rd  = f_rd;
      d_we  = 1'b1;
    end else begin
      case (op)
        4'h8: begin
          d_a   = rd_val;
          d_imm = imm_sext;
          d_rd  = f_rd;
          d_we  = 1'b1;
        end
        4'h9: begin
          d_a  = rs_val;
          d_rd = f_rd;
          d_re = 1'b1;
          d_we = 1'b1;
        end
        4'hA: begin
          d_a   = rs_val;
          d_b   = rd_val;
          d_mwe = 1'b1;
        end
        4'hB: begin
          d_a   = rd_val;
          d_imm = imm_sext;
        end
        4'hC: d_a = rs_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SQUASH;
      halt_pc   <= '0;
      HALTED    <= 1'b0;
      NPC_ID    <= '0;
      A_ID      <= '0;
      B_ID      <= '0;
      IMM_ID    <= '0;
      RD_ID     <= '0;
      ALU_OP_ID <= '0;
      REG_WE_ID <= 1'b0;
      MEM_RE_ID <= 1'b0;
      MEM_WE_ID <= 1'b0;
      VALID_ID  <= 1'b0;
    end else begin
      NPC_ID <= NPC_IF;
      // Bubble by default; RUN overrides with the decoded instruction.
      A_ID      <= '0;
      B_ID      <= '0;
      IMM_ID    <= '0;
      RD_ID     <= '0;
      ALU_OP_ID <= '0;
      REG_WE_ID <= 1'b0;
      MEM_RE_ID <= 1'b0;
      MEM_WE_ID <= 1'b0;
      VALID_ID  <= 1'b0;
      case (state)
        ST_RUN: begin
          if (op == 4'hF) begin
            // HALT itself enters ID/EX as a bubble.
            halt_pc <= NPC_IF - {{(DATA_W-1){1'b0}}, 1'b1};
            HALTED  <= 1'b1;
            state   <= ST_HALT;
          end else begin
            A_ID      <= d_a;
            B_ID      <= d_b;
            IMM_ID    <= d_imm;
            RD_ID     <= d_rd;
            ALU_OP_ID <= d_alu;
            REG_WE_ID <= d_we;
            MEM_RE_ID <= d_re;
            MEM_WE_ID <= d_mwe;
            VALID_ID  <= 1'b1;
            state     <= br_taken ? ST_SQUASH : ST_RUN;
          end
        end
        ST_SQUASH: state <= ST_RUN;
        default:   state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] NPC_IF, INST_IF, WB_DATA;
  logic        WB_EN;
  logic [3:0]  WB_ADDR;
  logic [15:0] TARGET, NPC_ID, A_ID, B_ID, IMM_ID;
  logic        TARGET_EN, REG_WE_ID, MEM_RE_ID, MEM_WE_ID, VALID_ID, HALTED;
  logic [3:0]  RD_ID;
  logic [2:0]  ALU_OP_ID;

  instruction_decode dut (
    .clk(clk), .rst(rst), .NPC_IF(NPC_IF), .INST_IF(INST_IF),
    .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .TARGET(TARGET), .TARGET_EN(TARGET_EN), .NPC_ID(NPC_ID),
    .A_ID(A_ID), .B_ID(B_ID), .IMM_ID(IMM_ID), .RD_ID(RD_ID),
    .ALU_OP_ID(ALU_OP_ID), .REG_WE_ID(REG_WE_ID), .MEM_RE_ID(MEM_RE_ID),
    .MEM_WE_ID(MEM_WE_ID), .VALID_ID(VALID_ID), .HALTED(HALTED)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          comb;
    string       n;
    logic [4:0]  m;   // [0]=A [1]=B [2]=IMM [3]=RD [4]=ALU
    logic [15:0] a, b, imm, tgt;
    logic [3:0]  rd;
    logic [2:0]  alu;
    logic        v, we, re, mwe, h, en;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [4:0] MA = 5'b00001, MB = 5'b00010, MI = 5'b00100,
                         MR = 5'b01000, ML = 5'b10000;

  function automatic void chk(string n, string f, logic [15:0] act, logic [15:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", n, f, act, ex);
    end
  endfunction

  task automatic exp_comb(input string n, input logic en, input logic [15:0] t, input logic h);
    exp_t e;
    e = '{due: cyc, comb: 1'b1, n: n, m: 5'b0, a: 16'h0, b: 16'h0, imm: 16'h0,
          tgt: t, rd: 4'h0, alu: 3'h0, v: 1'b0, we: 1'b0, re: 1'b0, mwe: 1'b0,
          h: h, en: en};
    q.push_back(e);
  endtask

  task automatic exp_reg(input int dly, input string n, input logic [4:0] m,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                         input logic [3:0] rd, input logic [2:0] alu,
                         input logic v, input logic we, input logic re,
                         input logic mwe, input logic h);
    exp_t e;
    e = '{due: cyc + dly, comb: 1'b0, n: n, m: m, a: a, b: b, imm: imm,
          tgt: 16'h0, rd: rd, alu: alu, v: v, we: we, re: re, mwe: mwe,
          h: h, en: 1'b0};
    q.push_back(e);
  endtask

  // Monitor: compare every expectation that has come due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.comb) begin
          chk(e.n, "TARGET_EN", 16'(TARGET_EN), 16'(e.en));
          chk(e.n, "TARGET", TARGET, e.tgt);
          chk(e.n, "HALTED", 16'(HALTED), 16'(e.h));
        end else begin
          if (e.m[0]) chk(e.n, "A_ID", A_ID, e.a);
          if (e.m[1]) chk(e.n, "B_ID", B_ID, e.b);
          if (e.m[2]) chk(e.n, "IMM_ID", IMM_ID, e.imm);
          if (e.m[3]) chk(e.n, "RD_ID", 16'(RD_ID), 16'(e.rd));
          if (e.m[4]) chk(e.n, "ALU_OP_ID", 16'(ALU_OP_ID), 16'(e.alu));
          chk(e.n, "VALID_ID", 16'(VALID_ID), 16'(e.v));
          chk(e.n, "REG_WE_ID", 16'(REG_WE_ID), 16'(e.we));
          chk(e.n, "MEM_RE_ID", 16'(MEM_RE_ID), 16'(e.re));
          chk(e.n, "MEM_WE_ID", 16'(MEM_WE_ID), 16'(e.mwe));
          chk(e.n, "HALTED", 16'(HALTED), 16'(e.h));
        end
      end
    end
  end

  task automatic drive(input logic [15:0] npc, input logic [15:0] inst,
                       input logic wen, input logic [3:0] waddr, input logic [15:0] wdata);
    NPC_IF  = npc;
    INST_IF = inst;
    WB_EN   = wen;
    WB_ADDR = waddr;
    WB_DATA = wdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shorthand for an ID/EX bubble / no-enable expectation due next cycle.
  task automatic exp_ctl(input string n, input logic v, input logic h);
    exp_reg(1, n, 5'b0, 16'h0, 16'h0, 16'h0, 4'h0, 3'h0, v, 1'b0, 1'b0, 1'b0, h);
  endtask

  initial begin
    rst = 1'b1;
    drive(16'h0, 16'h0, 1'b0, 4'h0, 16'h0);
    exp_comb("reset", 1'b0, 16'h0, 1'b0);
    exp_reg(0, "reset", MA | MB | MI | MR | ML, 16'h0, 16'h0, 16'h0, 4'h0, 3'h0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Post-reset SQUASH: this fetch word is discarded.
    drive(16'h0001, 16'h1123, 1'b1, 4'd2, 16'h0005);
    exp_comb("sq_rst", 1'b0, 16'h0, 1'b0);
    exp_ctl("sq_rst", 1'b0, 1'b0);
    step();
    drive(16'h0002, 16'h1123, 1'b1, 4'd3, 16'h0003);
    exp_reg(1, "rtype", MA | MB | MR | ML, 16'h0005, 16'h0003, 16'h0, 4'd1, 3'd1,
            1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(16'h0003, 16'h0045, 1'b1, 4'd4, 16'hBEEF);
    exp_reg(1, "bypass", MA | MB, 16'hBEEF, 16'h0, 16'h0, 4'd0, 3'd0,
            1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(16'h0004, 16'h0005, 1'b1, 4'd0, 16'h1111);
    exp_reg(1, "r0_byp", MA | MB, 16'h0, 16'h0, 16'h0, 4'd0, 3'd0,
            1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(16'h0005, 16'h82FF, 1'b1, 4'd5, 16'h1234);
    exp_reg(1, "addi", MA | MI | MR | ML, 16'h0005, 16'h0, 16'hFFFF, 4'd2, 3'd0,
            1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(16'h0006, 16'hA360, 1'b0, 4'd0, 16'h0);
    exp_reg(1, "store", MA | MB, 16'h0, 16'h0003, 16'h0, 4'd0, 3'd0,
            1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(16'h0007, 16'h9140, 1'b0, 4'd0, 16'h0);
    exp_reg(1, "load", MA | MR, 16'hBEEF, 16'h0, 16'h0, 4'd1, 3'd0,
            1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();

    // Taken BZ (R1==0), then a squashed slot, then normal resume.
    drive(16'h0010, 16'hB1FE, 1'b0, 4'd0, 16'h0);
    exp_comb("bz_taken", 1'b1, 16'h000E, 1'b0);
    exp_ctl("bz_id", 1'b1, 1'b0);
    step();
    drive(16'h0011, 16'h1123, 1'b0, 4'd0, 16'h0);
    exp_comb("sq_br", 1'b0, 16'h0, 1'b0);
    exp_ctl("sq_br", 1'b0, 1'b0);
    step();
    drive(16'h000F, 16'h1123, 1'b0, 4'd0, 16'h0);
    exp_comb("resume", 1'b0, 16'h0, 1'b0);
    exp_reg(1, "resume", MA | MB, 16'h0005, 16'h0003, 16'h0, 4'd0, 3'd0,
            1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // Not-taken BZ: R1 becomes 7 through the bypass this very cycle.
    drive(16'h0010, 16'hB105, 1'b1, 4'd1, 16'h0007);
    exp_comb("bz_nt", 1'b0, 16'h0, 1'b0);
    exp_ctl("bz_nt", 1'b1, 1'b0);
    step();
    drive(16'h0011, 16'h1123, 1'b0, 4'd0, 16'h0);
    exp_reg(1, "no_squash", MA | MB, 16'h0005, 16'h0003, 16'h0, 4'd0, 3'd0,
            1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // JR R5, then a BZ R0 in the squash slot that must be ignored.
    drive(16'h0012, 16'hC050, 1'b0, 4'd0, 16'h0);
    exp_comb("jr", 1'b1, 16'h1234, 1'b0);
    exp_reg(1, "jr_id", MA, 16'h1234, 16'h0, 16'h0, 4'd0, 3'd0,
            1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(16'h0013, 16'hB000, 1'b0, 4'd0, 16'h0);
    exp_comb("sq_ignore", 1'b0, 16'h0, 1'b0);
    exp_ctl("sq_ignore", 1'b0, 1'b0);
    step();

    // BZ with address wrap: 0xFFFF + 2 = 0x0001.
    drive(16'hFFFF, 16'hB002, 1'b0, 4'd0, 16'h0);
    exp_comb("bz_wrap", 1'b1, 16'h0001, 1'b0);
    exp_ctl("bz_wrap", 1'b1, 1'b0);
    step();
    drive(16'h0000, 16'h0000, 1'b0, 4'd0, 16'h0);
    exp_comb("sq_wrap", 1'b0, 16'h0, 1'b0);
    exp_ctl("sq_wrap", 1'b0, 1'b0);
    step();

    // HALT at address 0x0020.
    drive(16'h0021, 16'hF000, 1'b0, 4'd0, 16'h0);
    exp_comb("halt_dec", 1'b0, 16'h0, 1'b0);
    exp_ctl("halt_id", 1'b0, 1'b1);
    step();
    drive(16'h0022, 16'h1123, 1'b1, 4'd7, 16'h00AA);
    exp_comb("halt_spin", 1'b1, 16'h0020, 1'b1);
    exp_ctl("halt_bub", 1'b0, 1'b1);
    step();
    drive(16'h0023, 16'hC050, 1'b0, 4'd0, 16'h0);
    exp_comb("halt_jr", 1'b1, 16'h0020, 1'b1);
    exp_ctl("halt_bub2", 1'b0, 1'b1);
    step();
    drive(16'h0024, 16'hB000, 1'b0, 4'd0, 16'h0);
    exp_comb("halt_bz", 1'b1, 16'h0020, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_comb("rst_halt", 1'b0, 16'h0, 1'b0);
    exp_reg(0, "rst_halt", MA | MB | MI | MR | ML, 16'h0, 16'h0, 16'h0, 4'h0, 3'h0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    step();
    rst = 1'b0;

    // Back to SQUASH, then registers read as cleared.
    drive(16'h0051, 16'h1123, 1'b0, 4'd0, 16'h0);
    exp_comb("sq_rst2", 1'b0, 16'h0, 1'b0);
    exp_ctl("sq_rst2", 1'b0, 1'b0);
    step();
    drive(16'h0052, 16'h1123, 1'b0, 4'd0, 16'h0);
    exp_reg(1, "rf_clear", MA | MB | MR | ML, 16'h0, 16'h0, 16'h0, 4'd1, 3'd1,
            1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(16'h0053, 16'hD000, 1'b0, 4'd0, 16'h0);
    exp_ctl("nop", 1'b1, 1'b0);
    step();
    drive(16'h0054, 16'hE000, 1'b0, 4'd0, 16'h0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
